// File: rtl/tt_input_debouncer.sv
// tt_input_debouncer: synchronise, debounce, edge-pulse and count rising edges of raw input pins
module tt_input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             count_clear,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [7:0]       event_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, s;
  logic [7:0]       count_q, count_d;
  logic [15:0]      sum;
  assign s = sync_q[SYNC_STAGES-1];
  // synchroniser shift chain, frozen while disabled
  always_comb begin
    sync_d[0] = ena ? raw_in : sync_q[0];
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = ena ? sync_q[k-1] : sync_q[k];
  end
  // per-bit debounce: count consecutive mismatches, accept on the last one
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      clean_d[i] = clean_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      if (ena) begin
        if (s[i] == clean_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]   = '0;
          clean_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end
  // saturating rise counter; clear beats same-edge rises
  always_comb begin
    sum = 16'(count_q);
    for (int i = 0; i < WIDTH; i++) sum = sum + 16'(rise_d[i]);
    count_d = count_clear ? 8'd0 : (sum > 16'd255 ? 8'hFF : sum[7:0]);
    count_d = ena | count_clear ? count_d : count_q;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end
  assign clean_out   = clean_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_count = count_q;
endmodule
